// File: rtl/error_stats_accumulator.sv
// rtl/error_stats_accumulator.sv - per-frame error statistics for a multiplier comparator stage (option: ERR_STATS_SQERR_EN)
module error_stats_accumulator #(
  parameter int N          = 8,
  parameter int FRAME_LOG2 = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2*N-1:0]            exact,
  input  logic [2*N-1:0]            approx,
  input  logic [2*N-1:0]            error,
  output logic                      busy,
  output logic                      done,
  output logic [2*N+FRAME_LOG2-1:0] sum_err,
  output logic [2*N-1:0]            max_err,
  output logic [FRAME_LOG2:0]       nz_count,
  output logic                      mismatch
`ifdef ERR_STATS_SQERR_EN
  ,
  output logic [4*N+FRAME_LOG2-1:0] sum_sq_err
`endif
);

  localparam int EW = 2 * N;
  localparam int SW = EW + FRAME_LOG2;
  localparam int CW = FRAME_LOG2 + 1;
  localparam logic [CW-1:0] FRAME_CNT = {1'b1, {FRAME_LOG2{1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_inc;
  logic [EW-1:0]   abs_diff;
  logic            accept;
  logic            clear;

  // A sample only lands while collecting; start only counts outside a frame.
  assign accept   = in_valid && (state_q == ACCUM);
  assign clear    = start && (state_q != ACCUM);
  assign cnt_inc  = cnt_q + CW'(1);
  assign abs_diff = (exact >= approx) ? (exact - approx) : (approx - exact);

  // State register; reset wins over everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and the state-decoded handshake/status outputs.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept && (cnt_inc == FRAME_CNT)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = start ? ACCUM : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Statistics: cleared by reset or an honoured start, updated on each accepted sample.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q    <= '0;
      sum_err  <= '0;
      max_err  <= '0;
      nz_count <= '0;
      mismatch <= 1'b0;
    end else if (accept) begin
      cnt_q   <= cnt_inc;
      sum_err <= sum_err + SW'(error);
      if (error > max_err) begin
        max_err <= error;
      end
      if (error != '0) begin
        nz_count <= nz_count + CW'(1);
      end
      if (abs_diff != error) begin
        mismatch <= 1'b1;
      end
    end
  end

`ifdef ERR_STATS_SQERR_EN
  logic [2*EW-1:0] err_sq;

  assign err_sq = (2*EW)'(error) * (2*EW)'(error);

  // Sum of squared errors, cleared and advanced alongside the other statistics.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sum_sq_err <= '0;
    end else if (accept) begin
      sum_sq_err <= sum_sq_err + (2*EW+FRAME_LOG2)'(err_sq);
    end
  end
`endif

endmodule

// File: tb/tb_error_stats_accumulator.sv
// tb/tb_error_stats_accumulator.sv - directed scoreboard bench for error_stats_accumulator
module tb_error_stats_accumulator;

  localparam int N  = 8;
  localparam int FL = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [15:0]   exact = '0;
  logic [15:0]   approx = '0;
  logic [15:0]   error = '0;
  logic          in_ready;
  logic          busy;
  logic          done;
  logic [17:0]   sum_err;
  logic [15:0]   max_err;
  logic [2:0]    nz_count;
  logic          mismatch;
`ifdef ERR_STATS_SQERR_EN
  logic [33:0]   sum_sq_err;
`endif

  error_stats_accumulator #(.N(N), .FRAME_LOG2(FL)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .exact    (exact),
    .approx   (approx),
    .error    (error),
    .busy     (busy),
    .done     (done),
    .sum_err  (sum_err),
    .max_err  (max_err),
    .nz_count (nz_count),
    .mismatch (mismatch)
`ifdef ERR_STATS_SQERR_EN
    ,
    .sum_sq_err (sum_sq_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] sum;
    logic [63:0] max;
    logic [63:0] nz;
    logic [63:0] mm;
    logic [63:0] sq;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          failed = 0;
  logic [63:0] m_sum, m_max, m_nz, m_mm, m_sq;
  int          m_cnt;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    m_sum = 0; m_max = 0; m_nz = 0; m_mm = 0; m_sq = 0; m_cnt = 0;
  endtask

  // Drive one accepted sample for one cycle and fold it into the reference model.
  task automatic accept(input logic [15:0] e, input logic [15:0] a, input logic [15:0] er);
    logic [63:0] d;
    in_valid = 1'b1;
    exact = e; approx = a; error = er;
    d = (e >= a) ? 64'(e - a) : 64'(a - e);
    m_sum += 64'(er);
    if (64'(er) > m_max) m_max = 64'(er);
    if (er != 0) m_nz++;
    if (d != 64'(er)) m_mm = 1;
    m_sq += 64'(er) * 64'(er);
    m_cnt++;
    if (m_cnt == 4) exp_q.push_back('{m_sum, m_max, m_nz, m_mm, m_sq});
    tick();
    in_valid = 1'b0;
  endtask

  task automatic begin_frame(input string tag);
    start = 1'b1;
    model_clear();
    tick();
    start = 1'b0;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    chk({tag, "_clr_sum"}, 64'(sum_err), 64'd0);
    chk({tag, "_clr_nz"}, 64'(nz_count), 64'd0);
    chk({tag, "_clr_mm"}, 64'(mismatch), 64'd0);
  endtask

  // Called on the cycle right after the fourth accept: done must be up now.
  task automatic finish_frame(input string tag);
    exp_t x;
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_in_ready_done"}, 64'(in_ready), 64'd0);
    if (exp_q.size() == 0) begin
      chk({tag, "_scoreboard_empty"}, 64'd0, 64'd1);
    end else begin
      x = exp_q.pop_front();
      chk({tag, "_sum"}, 64'(sum_err), x.sum);
      chk({tag, "_max"}, 64'(max_err), x.max);
      chk({tag, "_nz"}, 64'(nz_count), x.nz);
      chk({tag, "_mm"}, 64'(mismatch), x.mm);
`ifdef ERR_STATS_SQERR_EN
      chk({tag, "_sq"}, 64'(sum_sq_err), x.sq);
`endif
    end
  endtask

  initial begin
    model_clear();
    tick();
    tick();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_sum", 64'(sum_err), 64'd0);
    chk("rst_max", 64'(max_err), 64'd0);
    chk("rst_nz", 64'(nz_count), 64'd0);
    chk("rst_mm", 64'(mismatch), 64'd0);
    rst = 1'b0;
    tick();

    // Back-to-back frame
    begin_frame("b2b");
    accept(16'd49, 16'd16, 16'd33);
    accept(16'd16, 16'd16, 16'd0);
    accept(16'd65025, 16'd63504, 16'd1521);
    accept(16'd9, 16'd0, 16'd9);
    finish_frame("b2b");
    chk("b2b_sum_const", 64'(sum_err), 64'd1563);
    chk("b2b_max_const", 64'(max_err), 64'd1521);
    chk("b2b_nz_const", 64'(nz_count), 64'd3);
`ifdef ERR_STATS_SQERR_EN
    chk("b2b_sq_const", 64'(sum_sq_err), 64'd2314611);
`endif
    tick();
    chk("b2b_done_pulse", 64'(done), 64'd0);
    chk("b2b_idle_ready", 64'(in_ready), 64'd0);
    chk("b2b_hold_sum", 64'(sum_err), 64'd1563);

    // Same samples with stall cycles between them
    begin_frame("stall");
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: accept(16'd49, 16'd16, 16'd33);
        1: accept(16'd16, 16'd16, 16'd0);
        2: accept(16'd65025, 16'd63504, 16'd1521);
        default: accept(16'd9, 16'd0, 16'd9);
      endcase
      if (i < 3) begin
        error = 16'd99;
        tick();
        chk("stall_in_ready", 64'(in_ready), 64'd1);
        chk("stall_nz_hold", 64'(nz_count), m_nz);
        chk("stall_sum_hold", 64'(sum_err), m_sum);
      end
    end
    finish_frame("stall");
    chk("stall_sum_const", 64'(sum_err), 64'd1563);
    tick();

    // Inconsistent error input sets the sticky mismatch flag
    begin_frame("mm");
    accept(16'd49, 16'd16, 16'd30);
    chk("mm_set", 64'(mismatch), 64'd1);
    accept(16'd16, 16'd16, 16'd0);
    accept(16'd9, 16'd0, 16'd9);
    accept(16'd5, 16'd7, 16'd2);
    finish_frame("mm");
    tick();
    chk("mm_hold_idle", 64'(mismatch), 64'd1);

    // Reset mid-frame, with start and in_valid also high
    begin_frame("rst");
    accept(16'd49, 16'd16, 16'd33);
    accept(16'd9, 16'd0, 16'd9);
    rst = 1'b1; start = 1'b1; in_valid = 1'b1; error = 16'd7;
    tick();
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    model_clear();
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_sum", 64'(sum_err), 64'd0);
    chk("midrst_max", 64'(max_err), 64'd0);
    chk("midrst_nz", 64'(nz_count), 64'd0);
    tick();
    chk("midrst_still_idle", 64'(in_ready), 64'd0);
    begin_frame("post_rst");
    accept(16'd100, 16'd1, 16'd99);
    accept(16'd3, 16'd3, 16'd0);
    accept(16'd0, 16'd200, 16'd200);
    accept(16'd10, 16'd4, 16'd6);
    finish_frame("post_rst");
    tick();

    // start ignored in ACCUM, honoured in DONE without an IDLE cycle
    begin_frame("restart");
    accept(16'd20, 16'd10, 16'd10);
    accept(16'd8, 16'd2, 16'd6);
    start = 1'b1;
    accept(16'd1, 16'd0, 16'd1);
    start = 1'b0;
    chk("restart_ignored_busy", 64'(busy), 64'd1);
    chk("restart_ignored_nz", 64'(nz_count), 64'd3);
    accept(16'd4, 16'd4, 16'd0);
    finish_frame("restart");
    start = 1'b1;
    model_clear();
    tick();
    start = 1'b0;
    chk("restart_accum", 64'(busy), 64'd1);
    chk("restart_done_low", 64'(done), 64'd0);
    chk("restart_sum_clr", 64'(sum_err), 64'd0);
    chk("restart_max_clr", 64'(max_err), 64'd0);

    // Full-scale errors must not overflow the sum
    for (int i = 0; i < 4; i++) accept(16'd65535, 16'd0, 16'd65535);
    finish_frame("full");
    chk("full_sum_const", 64'(sum_err), 64'd262140);
    chk("full_max_const", 64'(max_err), 64'd65535);
    chk("full_nz_const", 64'(nz_count), 64'd4);
    tick();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
